// File: rtl/jk_bank_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : jk_bank_driver_if
// Description : Bundle between a JK bank driver and its environment.
//               Names carry the direction as seen from the driver.
//   tgt_i        requested bank value          tgt_valid_i  target valid
//   tgt_ready_o  driver accepts a target       q_in_i       current bank Q
//   j_o / k_o    per-bit JK excitation         busy_o       DRIVE or CHECK
//   done_o       bank reached target (pulse)   err_o        retries exhausted
//   mismatch_o   target xor Q at the last check
// Revision    : 1.0 - initial release
// ============================================================================
interface jk_bank_driver_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tgt_i;
  logic             tgt_valid_i;
  logic             tgt_ready_o;
  logic [WIDTH-1:0] q_in_i;
  logic [WIDTH-1:0] j_o;
  logic [WIDTH-1:0] k_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
  logic [WIDTH-1:0] mismatch_o;

  modport master (
    output tgt_i, tgt_valid_i, q_in_i,
    input  tgt_ready_o, j_o, k_o, busy_o, done_o, err_o, mismatch_o
  );

  modport slave (
    input  tgt_i, tgt_valid_i, q_in_i,
    output tgt_ready_o, j_o, k_o, busy_o, done_o, err_o, mismatch_o
  );
endinterface
`default_nettype wire

// File: rtl/jk_bank_driver.sv
`default_nettype none
// ============================================================================
// Module      : jk_bank_driver
// Description : Drives an external bank of JK flip-flops towards a requested
//               value, verifies the result and retries a bounded number of
//               times. IDLE -> DRIVE (one cycle) -> CHECK -> IDLE/DRIVE.
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous active-low reset
//               bus_if - jk_bank_driver_if.slave (target handshake, bank Q,
//                        J/K excitation, status pulses, mismatch report)
// Parameters  : WIDTH      - number of flip-flops in the bank
//               MAX_RETRY  - extra drive attempts after a failed check
//               USE_TOGGLE - 1: J=K=1 on changing bits, 0: set/reset drive
// Revision    : 1.0 - initial release
// ============================================================================
module jk_bank_driver #(
  parameter int WIDTH      = 8,
  parameter int MAX_RETRY  = 2,
  parameter int USE_TOGGLE = 1
) (
  input  wire              clk,
  input  wire              rst_n,
  jk_bank_driver_if.slave  bus_if
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] C_MAX_RETRY = RW'(MAX_RETRY);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] j_q, k_q;
  logic [WIDTH-1:0] mismatch_q;
  logic [RW-1:0]    retry_q;
  logic             done_q, err_q;

  // On the accept edge the target register is not loaded yet, so the
  // excitation is computed from the incoming target; on a retry it comes
  // from the latched target.
  logic [WIDTH-1:0] drive_tgt;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] j_d, k_d;

  assign drive_tgt = (state_q == S_IDLE) ? bus_if.tgt_i : target_q;
  assign diff      = drive_tgt ^ bus_if.q_in_i;

  // Bits that already match are held (J=K=0) in both drive styles.
  generate
    if (USE_TOGGLE != 0) begin : g_toggle
      assign j_d = diff;
      assign k_d = diff;
    end else begin : g_setreset
      assign j_d = diff & drive_tgt;
      assign k_d = diff & ~drive_tgt;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      target_q   <= '0;
      j_q        <= '0;
      k_q        <= '0;
      mismatch_q <= '0;
      retry_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // Excitation and status pulses default to inactive; only the edges
      // entering DRIVE or leaving CHECK override them.
      j_q    <= '0;
      k_q    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus_if.tgt_valid_i) begin
            target_q   <= bus_if.tgt_i;
            retry_q    <= '0;
            mismatch_q <= '0;
            j_q        <= j_d;
            k_q        <= k_d;
            state_q    <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          mismatch_q <= target_q ^ bus_if.q_in_i;
          if (bus_if.q_in_i == target_q) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else if (retry_q < C_MAX_RETRY) begin
            retry_q <= retry_q + RW'(1);
            j_q     <= j_d;
            k_q     <= k_d;
            state_q <= S_DRIVE;
          end else begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus_if.tgt_ready_o = (state_q == S_IDLE);
  assign bus_if.busy_o      = (state_q != S_IDLE);
  assign bus_if.j_o         = j_q;
  assign bus_if.k_o         = k_q;
  assign bus_if.done_o      = done_q;
  assign bus_if.err_o       = err_q;
  assign bus_if.mismatch_o  = mismatch_q;

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_bank_driver
// Description : Self-checking bench for jk_bank_driver. Two instances share
//               the target stream: A toggles (USE_TOGGLE=1), B uses set/reset
//               drive; both allow two retries. Each instance drives its own
//               behavioural JK bank with an optional stuck-at-0 mask. The
//               expected cycle-by-cycle outputs of a transaction come from an
//               attempt-level model of the driving rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_bank_driver;

  localparam int C_W         = 8;
  localparam int C_MAX_RETRY = 2;

  logic clk;
  logic rst_n;

  jk_bank_driver_if #(.WIDTH(C_W)) bus_a ();
  jk_bank_driver_if #(.WIDTH(C_W)) bus_b ();

  jk_bank_driver #(.WIDTH(C_W), .MAX_RETRY(C_MAX_RETRY), .USE_TOGGLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus_if(bus_a)
  );
  jk_bank_driver #(.WIDTH(C_W), .MAX_RETRY(C_MAX_RETRY), .USE_TOGGLE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus_if(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural JK banks: Q+ = J&~Q | ~K&Q, stuck bits forced low.
  logic [C_W-1:0] bank_a, bank_b, stuck, load_val;
  logic           load_en;

  always @(posedge clk) begin
    if (load_en) begin
      bank_a <= load_val & ~stuck;
      bank_b <= load_val & ~stuck;
    end else begin
      bank_a <= ((bus_a.j_o & ~bank_a) | (~bus_a.k_o & bank_a)) & ~stuck;
      bank_b <= ((bus_b.j_o & ~bank_b) | (~bus_b.k_o & bank_b)) & ~stuck;
    end
  end

  assign bus_a.q_in_i = bank_a;
  assign bus_b.q_in_i = bank_b;

  int n_chk;
  int n_fail;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic set_tgt(input logic [7:0] t, input logic v);
    bus_a.tgt_i = t;  bus_a.tgt_valid_i = v;
    bus_b.tgt_i = t;  bus_b.tgt_valid_i = v;
  endtask

  // Expected outputs per cycle after the accept edge (index 1 = first cycle).
  logic [7:0] e_ja [1:15], e_ka [1:15], e_jb [1:15], e_kb [1:15], e_mm [1:15];
  logic       e_busy [1:15], e_done [1:15], e_err [1:15];
  logic [7:0] model_bank;

  task automatic set_exp(input int c, input logic busy, input logic [7:0] ja,
                         input logic [7:0] jb, input logic [7:0] kb,
                         input logic [7:0] mm);
    e_busy[c] = busy; e_done[c] = 1'b0; e_err[c] = 1'b0;
    e_ja[c] = ja; e_ka[c] = ja; e_jb[c] = jb; e_kb[c] = kb; e_mm[c] = mm;
  endtask

  task automatic check_cycle(input string tag, input int c);
    chk1($sformatf("%s c%0d busyA", tag, c), bus_a.busy_o, e_busy[c]);
    chk1($sformatf("%s c%0d busyB", tag, c), bus_b.busy_o, e_busy[c]);
    chk1($sformatf("%s c%0d readyA", tag, c), bus_a.tgt_ready_o, !e_busy[c]);
    chk1($sformatf("%s c%0d doneA", tag, c), bus_a.done_o, e_done[c]);
    chk1($sformatf("%s c%0d doneB", tag, c), bus_b.done_o, e_done[c]);
    chk1($sformatf("%s c%0d errA", tag, c), bus_a.err_o, e_err[c]);
    chk1($sformatf("%s c%0d errB", tag, c), bus_b.err_o, e_err[c]);
    chk8($sformatf("%s c%0d jA", tag, c), bus_a.j_o, e_ja[c]);
    chk8($sformatf("%s c%0d kA", tag, c), bus_a.k_o, e_ka[c]);
    chk8($sformatf("%s c%0d jB", tag, c), bus_b.j_o, e_jb[c]);
    chk8($sformatf("%s c%0d kB", tag, c), bus_b.k_o, e_kb[c]);
    chk8($sformatf("%s c%0d mmA", tag, c), bus_a.mismatch_o, e_mm[c]);
    chk8($sformatf("%s c%0d mmB", tag, c), bus_b.mismatch_o, e_mm[c]);
  endtask

  // One transaction, entered and left on a falling edge. With busy_valid the
  // target busy_tgt is held valid from the first busy cycle onward and the
  // task returns in the DONE/ERR cycle so the next call is back-to-back.
  task automatic run_txn(input string tag, input logic [7:0] q0, input logic [7:0] tgt,
                         input logic [7:0] stk, input bit do_load,
                         input logic [7:0] busy_tgt, input bit busy_valid);
    logic [7:0] q, mm, diff;
    int c, att, last;
    bit fin, ok;
    if (do_load) begin
      stuck = stk; load_val = q0; load_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      load_en = 1'b0;
      model_bank = q0 & ~stk;
    end
    // Attempt-level model: each drive brings every non-stuck bit to target.
    q = model_bank; mm = 8'h00; c = 1; att = 0; fin = 0; ok = 0;
    while (!fin) begin
      att++;
      diff = tgt ^ q;
      set_exp(c, 1'b1, diff, diff & tgt, diff & ~tgt, mm);
      q = tgt & ~stuck;
      set_exp(c + 1, 1'b1, 8'h00, 8'h00, 8'h00, mm);
      mm = tgt ^ q;
      if (q == tgt) begin
        fin = 1; ok = 1;
      end else if (att == C_MAX_RETRY + 1) begin
        fin = 1;
      end
      c += 2;
    end
    last = c;
    set_exp(last, 1'b0, 8'h00, 8'h00, 8'h00, mm);
    e_done[last] = ok;
    e_err[last]  = !ok;

    set_tgt(tgt, 1'b1);
    chk1({tag, " readyA pre"}, bus_a.tgt_ready_o, 1'b1);
    chk1({tag, " readyB pre"}, bus_b.tgt_ready_o, 1'b1);
    @(posedge clk);
    for (int cc = 1; cc <= last; cc++) begin
      @(negedge clk);
      if (cc == 1) set_tgt(busy_tgt, busy_valid);
      check_cycle(tag, cc);
    end
    model_bank = q;
    if (!busy_valid) begin
      @(negedge clk);
      chk1({tag, " post doneA"}, bus_a.done_o, 1'b0);
      chk1({tag, " post errA"}, bus_a.err_o, 1'b0);
      chk1({tag, " post doneB"}, bus_b.done_o, 1'b0);
      chk1({tag, " post errB"}, bus_b.err_o, 1'b0);
      chk1({tag, " post readyA"}, bus_a.tgt_ready_o, 1'b1);
      chk8({tag, " post mmA"}, bus_a.mismatch_o, mm);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rq, rt, rs;
    n_chk = 0; n_fail = 0;
    load_en = 1'b0; load_val = 8'h00; stuck = 8'h00; model_bank = 8'h00;
    set_tgt(8'h00, 1'b0);
    rst_n = 1'b0;
    #1;
    chk1("rst readyA", bus_a.tgt_ready_o, 1'b1);
    chk1("rst busyA", bus_a.busy_o, 1'b0);
    chk1("rst doneA", bus_a.done_o, 1'b0);
    chk1("rst errA", bus_a.err_o, 1'b0);
    chk8("rst jA", bus_a.j_o, 8'h00);
    chk8("rst kB", bus_b.k_o, 8'h00);
    chk8("rst mmA", bus_a.mismatch_o, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk1("rst release readyA", bus_a.tgt_ready_o, 1'b1);
    @(negedge clk);

    // Directed cases from the requirement examples.
    run_txn("a5", 8'h00, 8'hA5, 8'h00, 1, 8'h00, 0);
    run_txn("f0", 8'h0F, 8'hF0, 8'h00, 1, 8'h00, 0);
    run_txn("same", 8'h3C, 8'h3C, 8'h00, 1, 8'h00, 0);
    run_txn("stuck", 8'h00, 8'h01, 8'h01, 1, 8'h00, 0);

    // Back-to-back: 0x55 held valid while busy, accepted in the DONE cycle.
    run_txn("b2b1", 8'h0F, 8'hC3, 8'h00, 1, 8'h55, 1);
    run_txn("b2b2", 8'h00, 8'h55, 8'h00, 0, 8'h00, 0);

    // Reset in the middle of DRIVE.
    stuck = 8'h00; load_val = 8'h00; load_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_en = 1'b0;
    set_tgt(8'h3C, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_tgt(8'h00, 1'b0);
    chk8("mid jA before rst", bus_a.j_o, 8'h3C);
    rst_n = 1'b0;
    #1;
    chk8("mid rst jA", bus_a.j_o, 8'h00);
    chk8("mid rst kA", bus_a.k_o, 8'h00);
    chk8("mid rst jB", bus_b.j_o, 8'h00);
    chk1("mid rst busyA", bus_a.busy_o, 1'b0);
    chk1("mid rst readyA", bus_a.tgt_ready_o, 1'b1);
    chk1("mid rst readyB", bus_b.tgt_ready_o, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk1($sformatf("after rst c%0d doneA", i), bus_a.done_o, 1'b0);
      chk1($sformatf("after rst c%0d errA", i), bus_a.err_o, 1'b0);
      chk1($sformatf("after rst c%0d errB", i), bus_b.err_o, 1'b0);
      chk1($sformatf("after rst c%0d readyA", i), bus_a.tgt_ready_o, 1'b1);
    end

    // Randomised transactions, some with a stuck bit, some already at target.
    for (int i = 0; i < 40; i++) begin
      rq = 8'($urandom);
      rt = ($urandom_range(0, 5) == 0) ? rq : 8'($urandom);
      rs = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      run_txn($sformatf("rnd%0d", i), rq, rt, rs, 1, 8'h00, 0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jk_bank_driver.md
JK_BANK_DRIVER -- requirements
Module: jk_bank_driver

Interface
REQ-001 Parameter WIDTH, default 8: number of JK flip-flops in the driven bank.
REQ-002 Parameter MAX_RETRY, default 2: extra DRIVE attempts after a failed check; 0 means no retry.
REQ-003 Parameter USE_TOGGLE, default 1: 1 drives changing bits with J=K=1; 0 drives them with set (J=1,K=0) or reset (J=0,K=1).
REQ-004 CLK  input  1  single clock; all state changes on rising edge.
REQ-005 RST_N  input  1  reset, asynchronous, active-low.
REQ-006 TGT  input  WIDTH  requested bank value.
REQ-007 TGT_VALID  input  1  TGT is valid this cycle.
REQ-008 TGT_READY  output  1  block accepts a target this cycle; high only in IDLE.
REQ-009 Q_IN  input  WIDTH  current Q of the external JK bank.
REQ-010 J  output  WIDTH  per-bit J excitation to the bank, registered.
REQ-011 K  output  WIDTH  per-bit K excitation to the bank, registered.
REQ-012 BUSY  output  1  high in DRIVE and CHECK.
REQ-013 DONE  output  1  one-cycle pulse: bank reached target.
REQ-014 ERR  output  1  one-cycle pulse: retries exhausted, bank not at target.
REQ-015 MISMATCH  output  WIDTH  TGT xor Q_IN captured at the last CHECK; cleared on accept.

Function
REQ-016 The block SHALL implement states IDLE, DRIVE, CHECK.
REQ-017 Accept occurs on a rising edge with state IDLE and TGT_VALID=1; TGT SHALL be latched into an internal target register, the retry counter cleared, MISMATCH cleared, state set to DRIVE.
REQ-018 On every edge entering DRIVE, with diff = target xor Q_IN: USE_TOGGLE=1 loads J=K=diff; USE_TOGGLE=0 loads J=diff&target, K=diff&~target.
REQ-019 Bits with diff=0 SHALL always be driven J=0,K=0 (hold).
REQ-020 DRIVE SHALL last exactly one cycle; the edge leaving DRIVE loads J=0,K=0 and enters CHECK.
REQ-021 J and K SHALL be all-zero in every state other than DRIVE.
REQ-022 In CHECK, Q_IN==target: next edge SHALL return to IDLE with DONE=1 for that one IDLE cycle.
REQ-023 In CHECK, mismatch and retry count < MAX_RETRY: next edge SHALL increment the retry count and re-enter DRIVE, recomputing J/K from current Q_IN.
REQ-024 In CHECK, mismatch and retry count == MAX_RETRY: next edge SHALL return to IDLE with ERR=1 for one cycle.
REQ-025 MISMATCH SHALL be updated at every CHECK edge and held until the next accept.
REQ-026 Retry counter width SHALL be clog2(MAX_RETRY+1), minimum 1 bit; it SHALL never wrap.
REQ-027 Latency: accept at edge n; J/K visible cycle n+1; CHECK cycle n+2; DONE cycle n+3 on first-attempt success; each retry adds 2 cycles.
REQ-028 TGT_VALID while BUSY=1 SHALL be ignored (TGT_READY=0); no queueing.
REQ-029 An accept in the same cycle DONE or ERR is high SHALL be honoured (back-to-back operation).
REQ-030 A target equal to Q_IN SHALL still pass through DRIVE and CHECK with J=K=0 and end in DONE.
REQ-031 DONE and ERR SHALL never be high in the same cycle.

Reset
REQ-032 RST_N=0 SHALL immediately force state IDLE, J=0, K=0, BUSY=0, DONE=0, ERR=0, MISMATCH=0, retry count 0, target register 0, regardless of state.
REQ-033 TGT_READY SHALL be 1 while in reset and in the first cycle after RST_N rises; an in-flight operation is discarded with no DONE/ERR.

Verification
REQ-034 WIDTH=8, USE_TOGGLE=1, bank model Q_IN=0x00, TGT=0xA5 accepted at edge n -> J=K=0xA5 in cycle n+1, Q_IN=0xA5 in n+2, DONE=1 in n+3, MISMATCH=0x00.
REQ-035 USE_TOGGLE=0, Q_IN=0x0F, TGT=0xF0 -> DRIVE cycle J=0xF0, K=0x0F; DONE in n+3.
REQ-036 Q_IN=0x3C, TGT=0x3C -> J=K=0x00 throughout, DONE in n+3.
REQ-037 MAX_RETRY=2, bank bit0 stuck at 0, TGT=0x01 -> three DRIVE cycles (J[0]=1 each), ERR=1 in n+7, MISMATCH=0x01, DONE never high.
REQ-038 RST_N driven low mid-DRIVE -> J=K=0x00, BUSY=0, TGT_READY=1 in the same cycle, no DONE/ERR after release.
REQ-039 TGT_VALID held high with TGT=0x55 during BUSY, then 0x55 presented in the DONE cycle -> ignored while busy, accepted in the DONE cycle, second DONE exactly 3 cycles later.
